atm_pin_entry: RTL and testbench
================================

// Module: atm_pin_entry
// PURPOSE
//  Upstream stage of the ATM controller. Collects keypad digit strobes into a BCD PIN word.
//  Delivers the PIN to the controller's pin input through a valid/ready handshake.
//  Supports clear, backspace and enter keys, plus an optional inactivity timeout.
//  Keys 1,2,3,4 then ENTER produce pin_value=16'h1234.
// PARAMETERS
//  PIN_DIGITS      4       number of BCD digits per PIN; pin_value width = 4*PIN_DIGITS
//  TIMEOUT_CYCLES  1000    idle cycles before a partial entry is discarded (timeout build only)
//  CNT_W           3       width of digit_count; >= clog2(PIN_DIGITS+1)
// PORTS
//  clk            in   1             system clock, rising edge
//  rst            in   1             synchronous reset, active-high
//  card_inserted  in   1             level; low forces the block idle and clears the entry
//  key_valid      in   1             one-cycle strobe, already debounced, with key_code
//  key_code       in   4             0x0-0x9 digit, 0xA CLEAR, 0xB BACKSPACE, 0xE ENTER, others invalid
//  pin_ready      in   1             downstream accepts pin_value this cycle
//  pin_value      out  4*PIN_DIGITS  BCD PIN, first key in the most significant nibble
//  pin_valid      out  1             pin_value is complete and held stable
//  digit_count    out  CNT_W         digits currently buffered, for the masked display
//  entry_error    out  1             one-cycle pulse on a rejected key
//  entry_timeout  out  1             one-cycle pulse when a partial entry is discarded
// BEHAVIOUR
//  Reset: state=IDLE, pin_value=0, pin_valid=0, digit_count=0, entry_error=0, entry_timeout=0.
//  All outputs are registered. A key sampled in cycle N is reflected in cycle N+1.
//  States:
//   IDLE:  card_inserted=1 -> ENTRY. All keys are ignored and raise no error.
//   ENTRY:
//    - digit, count<PIN_DIGITS: shift the buffer left by 4 and insert the digit at nibble 0; count++.
//    - digit, count==PIN_DIGITS: buffer unchanged; entry_error pulse.
//    - BACKSPACE, count>0: shift the buffer right by 4; count--.
//    - BACKSPACE, count==0: no effect and no error.
//    - CLEAR: buffer=0, count=0; no error.
//    - ENTER, count==PIN_DIGITS: -> HOLD; pin_valid=1 the next cycle.
//    - ENTER, count<PIN_DIGITS: buffer kept; entry_error pulse.
//    - Invalid code (0xC, 0xD, 0xF): buffer unchanged; entry_error pulse.
//   HOLD:
//    - pin_valid=1 and pin_value stable. Keys are ignored and raise no error.
//    - pin_valid & pin_ready: -> ENTRY next cycle with buffer=0, count=0, pin_valid=0.
//    - pin_ready asserted in the same cycle pin_valid first rises counts as accepted.
//  Card removal (card_inserted=0 in any state) -> IDLE next cycle.
//   Buffer and count are cleared and pin_valid drops.
//   Card removal wins over a simultaneous key_valid or pin_ready.
//  rst mid-operation: the reset state is restored on the next edge and any held PIN is lost.
// CONFIGURATION
//  ATM_PIN_TIMEOUT_EN defined:
//   - An idle counter runs only in ENTRY with count>0.
//   - It is cleared by any key_valid accepted in ENTRY and by leaving ENTRY.
//   - When it reaches TIMEOUT_CYCLES-1: buffer=0, count=0, and entry_timeout pulses for one cycle.
//   - If a key arrives in that same cycle, the timeout is taken and the key is dropped.
//  ATM_PIN_TIMEOUT_EN undefined: no counter is built and entry_timeout is tied to 0.
// STRUCTURE
//  atm_pkg:
//   - Key-code localparams: KEY_CLEAR=4'hA, KEY_BKSP=4'hB, KEY_ENTER=4'hE.
//   - 2-bit state encoding: IDLE=0, ENTRY=1, HOLD=2.
//   - Shared with atm_module.
//  Sub-module atm_entry_timer:
//   - Parameterised down-counter with clear/enable inputs and an expire pulse output.
//   - Instantiated only under ATM_PIN_TIMEOUT_EN.
// TESTING
//  1. card=1; keys 1,2,3,4,ENTER; pin_ready=0 -> pin_valid=1, pin_value=16'h1234, held.
//     Then pin_ready=1 for one cycle -> pin_valid=0 and digit_count=0 the next cycle.
//  2. Keys 5,6,BKSP,7,8,9,ENTER -> pin_value=16'h5789.
//     A fifth digit before ENTER -> entry_error pulse, value unchanged.
//  3. Keys 1,2,ENTER -> entry_error pulse, digit_count stays 2.
//     Key 0xC -> entry_error pulse. CLEAR -> digit_count=0.
//  4. In HOLD with pin 16'h1234, drop card_inserted -> IDLE next cycle, pin_valid=0, pin_value=0.
//     Keys pressed while in IDLE -> no change and no error.
//  5. ATM_PIN_TIMEOUT_EN, TIMEOUT_CYCLES=8: key 3 then 8 idle cycles
//     -> entry_timeout pulse, digit_count=0.
//     Without the macro, the same stimulus leaves digit_count=1.
//  6. Assert rst during entry of digits 9,9 -> all outputs at their reset values next cycle.

Source files
------------

// File: rtl/atm_pkg.sv
// rtl/atm_pkg.sv - shared key codes, state encoding and helpers for the ATM PIN entry block
// Purpose: key-code constants, FSM state type and a digit classifier shared by the
//          PIN entry top, its interface users and the rest of the ATM controller.
// Ports:   none (package).
package atm_pkg;

  localparam logic [3:0] KEY_CLEAR = 4'hA;
  localparam logic [3:0] KEY_BKSP  = 4'hB;
  localparam logic [3:0] KEY_ENTER = 4'hE;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ENTRY = 2'd1,
    HOLD  = 2'd2
  } state_t;

  function automatic logic is_digit(input logic [3:0] code);
    return code <= 4'd9;
  endfunction

endpackage

// File: rtl/atm_pin_entry_if.sv
// rtl/atm_pin_entry_if.sv - keypad in / PIN out signal bundle for atm_pin_entry
// Purpose: groups the card level, keypad strobe and PIN valid/ready handshake.
// Ports (signals):
//   card_inserted, key_valid, key_code[3:0], pin_ready       - toward the PIN entry block
//   pin_value[4*PIN_DIGITS-1:0], pin_valid, digit_count,
//   entry_error, entry_timeout                               - from the PIN entry block
// Modports: master = keypad/controller side, slave = atm_pin_entry.
interface atm_pin_entry_if #(
  parameter int PIN_DIGITS = 4,
  parameter int CNT_W      = 3
);
  logic                    card_inserted;
  logic                    key_valid;
  logic [3:0]              key_code;
  logic                    pin_ready;
  logic [4*PIN_DIGITS-1:0] pin_value;
  logic                    pin_valid;
  logic [CNT_W-1:0]        digit_count;
  logic                    entry_error;
  logic                    entry_timeout;

  modport master (
    output card_inserted, key_valid, key_code, pin_ready,
    input  pin_value, pin_valid, digit_count, entry_error, entry_timeout
  );

  modport slave (
    input  card_inserted, key_valid, key_code, pin_ready,
    output pin_value, pin_valid, digit_count, entry_error, entry_timeout
  );
endinterface

// File: rtl/atm_entry_timer.sv
// rtl/atm_entry_timer.sv - inactivity down-counter with clear/enable and expire pulse
// Purpose: counts enabled cycles down from CYCLES-1; expire is high in the enabled
//          cycle the count sits at zero, after which the counter reloads.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   clr       - reload the counter (activity seen)
//   en        - count this cycle
//   expire    - combinational pulse, en && count==0
module atm_entry_timer #(
  parameter int CYCLES = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);
  localparam int W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [W-1:0] LOAD = W'(CYCLES - 1);

  logic [W-1:0] cnt_q;

  assign expire = en && (cnt_q == '0);

  always_ff @(posedge clk) begin
    if (rst || clr || expire) begin
      cnt_q <= LOAD;
    end else if (en) begin
      cnt_q <= cnt_q - W'(1);
    end
  end
endmodule

// File: rtl/atm_pin_entry.sv
// rtl/atm_pin_entry.sv - keypad digit collector delivering a BCD PIN over valid/ready
// Purpose: collects digit strobes into a BCD word (first key in the top nibble),
//          handles CLEAR/BACKSPACE/ENTER, and holds the finished PIN until accepted.
//          Build option ATM_PIN_TIMEOUT_EN adds an inactivity timeout that discards a
//          partial entry; without it entry_timeout is tied low.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   bus       - atm_pin_entry_if.slave: card_inserted, key_valid/key_code, pin_ready in;
//               pin_value/pin_valid, digit_count, entry_error, entry_timeout out
module atm_pin_entry
  import atm_pkg::*;
#(
  parameter int PIN_DIGITS     = 4,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int CNT_W          = 3
) (
  input  logic clk,
  input  logic rst,
  atm_pin_entry_if.slave bus
);
  localparam int W = 4 * PIN_DIGITS;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(PIN_DIGITS);

  state_t           state_q, state_d;
  logic [W-1:0]     buf_q, buf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             valid_q;
  logic             err_q, err_d;
  logic             tmo_q, tmo_d;
  logic             timer_expire;

`ifdef ATM_PIN_TIMEOUT_EN
  logic timer_clr;
  logic timer_en;

  // Any strobe seen in ENTRY counts as activity; outside ENTRY the timer is parked.
  assign timer_en  = (state_q == ENTRY) && (cnt_q != '0);
  assign timer_clr = (state_q != ENTRY) || bus.key_valid;

  atm_entry_timer #(
    .CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (timer_clr),
    .en     (timer_en),
    .expire (timer_expire)
  );
`else
  assign timer_expire = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    tmo_d   = 1'b0;
    if (!bus.card_inserted) begin
      // Card removal overrides every other input.
      state_d = IDLE;
      buf_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: state_d = ENTRY;
        ENTRY: begin
          if (timer_expire) begin
            // A key landing on the expiry cycle is dropped.
            buf_d = '0;
            cnt_d = '0;
            tmo_d = 1'b1;
          end else if (bus.key_valid) begin
            if (is_digit(bus.key_code)) begin
              if (cnt_q < FULL) begin
                buf_d = {buf_q[W-5:0], bus.key_code};
                cnt_d = cnt_q + CNT_W'(1);
              end else begin
                err_d = 1'b1;
              end
            end else begin
              case (bus.key_code)
                KEY_BKSP: begin
                  if (cnt_q != '0) begin
                    buf_d = buf_q >> 4;
                    cnt_d = cnt_q - CNT_W'(1);
                  end
                end
                KEY_CLEAR: begin
                  buf_d = '0;
                  cnt_d = '0;
                end
                KEY_ENTER: begin
                  if (cnt_q == FULL) state_d = HOLD;
                  else               err_d   = 1'b1;
                end
                default: err_d = 1'b1;
              endcase
            end
          end
        end
        HOLD: begin
          // pin_valid is high throughout HOLD, so pin_ready alone completes the handshake.
          if (bus.pin_ready) begin
            state_d = ENTRY;
            buf_d   = '0;
            cnt_d   = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      buf_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      valid_q <= (state_d == HOLD);
      err_q   <= err_d;
      tmo_q   <= tmo_d;
    end
  end

  assign bus.pin_value     = buf_q;
  assign bus.pin_valid     = valid_q;
  assign bus.digit_count   = cnt_q;
  assign bus.entry_error   = err_q;
  assign bus.entry_timeout = tmo_q;
endmodule

// File: tb/tb_atm_pin_entry.sv
// tb/tb_atm_pin_entry.sv - self-checking bench for atm_pin_entry with a queue-based model
module tb_atm_pin_entry;
  localparam int PD = 4;
  localparam int TC = 8;
  localparam int CW = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  atm_pin_entry_if #(.PIN_DIGITS(PD), .CNT_W(CW)) bus ();

  atm_pin_entry #(
    .PIN_DIGITS     (PD),
    .TIMEOUT_CYCLES (TC),
    .CNT_W          (CW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Model: 0 = no card, 1 = collecting digits, 2 = PIN offered downstream.
  int m_mode = 0;
  int m_digits[$];
  bit m_err = 1'b0;
  bit m_tmo = 1'b0;
  int m_idle = 0;

  function automatic logic [15:0] m_value();
    logic [15:0] v;
    v = 16'h0;
    foreach (m_digits[i]) v = (v << 4) | 16'(m_digits[i]);
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_key(input int code);
    if (code <= 9) begin
      if (m_digits.size() < PD) m_digits.push_back(code);
      else m_err = 1'b1;
    end else if (code == 'hB) begin
      if (m_digits.size() > 0) void'(m_digits.pop_back());
    end else if (code == 'hA) begin
      m_digits.delete();
    end else if (code == 'hE) begin
      if (m_digits.size() == PD) m_mode = 2;
      else m_err = 1'b1;
    end else begin
      m_err = 1'b1;
    end
  endtask

  // Reference model, advanced on every rising edge from the inputs present at that edge.
  initial forever begin
    bit handled;
    @(posedge clk);
    m_err = 1'b0;
    m_tmo = 1'b0;
    if (rst) begin
      m_mode = 0;
      m_digits.delete();
      m_idle = 0;
    end else if (!bus.card_inserted) begin
      m_mode = 0;
      m_digits.delete();
      m_idle = 0;
    end else if (m_mode == 0) begin
      m_mode = 1;
      m_idle = 0;
    end else if (m_mode == 1) begin
      handled = 1'b0;
`ifdef ATM_PIN_TIMEOUT_EN
      if (m_digits.size() > 0 && m_idle == TC - 1) begin
        m_digits.delete();
        m_tmo = 1'b1;
        m_idle = 0;
        handled = 1'b1;
      end
`endif
      if (!handled) begin
        if (bus.key_valid) begin
          m_idle = 0;
          m_key(int'(bus.key_code));
          if (m_mode != 1) m_idle = 0;
        end else if (m_digits.size() > 0) begin
          m_idle++;
        end else begin
          m_idle = 0;
        end
      end
    end else begin
      m_idle = 0;
      if (bus.pin_ready) begin
        m_mode = 1;
        m_digits.delete();
      end
    end
  end

  // Cycle-by-cycle comparison, away from the active edge.
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check("pin_value",     32'(bus.pin_value),     32'(m_value()));
      check("pin_valid",     32'(bus.pin_valid),     32'(m_mode == 2));
      check("digit_count",   32'(bus.digit_count),   32'(m_digits.size()));
      check("entry_error",   32'(bus.entry_error),   32'(m_err));
      check("entry_timeout", 32'(bus.entry_timeout), 32'(m_tmo));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] code);
    bus.key_valid = 1'b1;
    bus.key_code  = code;
    tick();
    bus.key_valid = 1'b0;
  endtask

  // Literal expectations applied to both the DUT and the model.
  task automatic expect_lit(input string name, input logic [15:0] val, input int cnt,
                            input bit vld, input bit err);
    check({name, " value dut"},   32'(bus.pin_value),   32'(val));
    check({name, " value model"}, 32'(m_value()),       32'(val));
    check({name, " count dut"},   32'(bus.digit_count), 32'(cnt));
    check({name, " count model"}, 32'(m_digits.size()), 32'(cnt));
    check({name, " valid dut"},   32'(bus.pin_valid),   32'(vld));
    check({name, " error dut"},   32'(bus.entry_error), 32'(err));
  endtask

  initial begin
    int kp;
    rst               = 1'b1;
    bus.card_inserted = 1'b0;
    bus.key_valid     = 1'b0;
    bus.key_code      = 4'h0;
    bus.pin_ready     = 1'b0;
    tick();
    chk_en = 1'b1;
    tick();
    expect_lit("reset", 16'h0, 0, 0, 0);
    check("reset timeout", 32'(bus.entry_timeout), 32'd0);
    rst = 1'b0;

    // 1: basic PIN, held until accepted
    bus.card_inserted = 1'b1;
    tick();
    press(4'h1); press(4'h2); press(4'h3); press(4'h4); press(4'hE);
    expect_lit("t1 enter", 16'h1234, 4, 1, 0);
    repeat (3) tick();
    expect_lit("t1 held", 16'h1234, 4, 1, 0);
    bus.pin_ready = 1'b1;
    tick();
    bus.pin_ready = 1'b0;
    expect_lit("t1 accepted", 16'h0, 0, 0, 0);

    // 2: backspace, overflow digit
    press(4'h5); press(4'h6); press(4'hB); press(4'h7); press(4'h8); press(4'h9);
    expect_lit("t2 digits", 16'h5789, 4, 0, 0);
    press(4'h3);
    expect_lit("t2 overflow", 16'h5789, 4, 0, 1);
    press(4'hE);
    expect_lit("t2 enter", 16'h5789, 4, 1, 0);
    bus.pin_ready = 1'b1;
    tick();
    bus.pin_ready = 1'b0;

    // 3: short ENTER, invalid code, CLEAR
    press(4'h1); press(4'h2); press(4'hE);
    expect_lit("t3 short enter", 16'h0012, 2, 0, 1);
    press(4'hC);
    expect_lit("t3 invalid", 16'h0012, 2, 0, 1);
    press(4'hA);
    expect_lit("t3 clear", 16'h0, 0, 0, 0);

    // 4: card removal in HOLD, keys ignored in IDLE
    press(4'h1); press(4'h2); press(4'h3); press(4'h4); press(4'hE);
    expect_lit("t4 hold", 16'h1234, 4, 1, 0);
    bus.card_inserted = 1'b0;
    tick();
    expect_lit("t4 removed", 16'h0, 0, 0, 0);
    press(4'h5); press(4'hE); press(4'hC);
    expect_lit("t4 idle keys", 16'h0, 0, 0, 0);
    bus.card_inserted = 1'b1;
    tick();

    // 5: inactivity after one digit
    press(4'h3);
    repeat (TC) tick();
`ifdef ATM_PIN_TIMEOUT_EN
    expect_lit("t5 timeout", 16'h0, 0, 0, 0);
    check("t5 timeout pulse", 32'(bus.entry_timeout), 32'd1);
`else
    expect_lit("t5 no timeout", 16'h0003, 1, 0, 0);
    check("t5 timeout pulse", 32'(bus.entry_timeout), 32'd0);
`endif
    press(4'hA);

    // 6: reset during entry
    press(4'h9); press(4'h9);
    expect_lit("t6 digits", 16'h0099, 2, 0, 0);
    rst = 1'b1;
    press(4'h9);
    expect_lit("t6 reset", 16'h0, 0, 0, 0);
    check("t6 reset timeout", 32'(bus.entry_timeout), 32'd0);
    rst = 1'b0;

    // Randomised traffic with varying key density so idle stretches occur.
    kp = 50;
    for (int i = 0; i < 4000; i++) begin
      if (i % 100 == 0) kp = $urandom_range(3, 70);
      rst               = ($urandom_range(0, 399) == 0);
      bus.card_inserted = ($urandom_range(0, 79) != 0);
      bus.key_valid     = ($urandom_range(0, 99) < kp);
      if ($urandom_range(0, 3) == 0) bus.key_code = 4'hE;
      else                           bus.key_code = 4'($urandom_range(0, 15));
      bus.pin_ready     = ($urandom_range(0, 2) == 0);
      tick();
    end
    rst           = 1'b0;
    bus.key_valid = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
